// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: the opcode constants used by the fetch unit and
// the control unit, the fetch FSM state type, and the fetch buffer entry width.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One buffered instruction: {pc, instruction word}
  localparam int FETCH_ENTRY_W = XLEN + ILEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // True for the opcodes this core implements
  function automatic logic opcode_supported(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Two-entry fetch buffer. Entry 0 is always the head, so the head outputs come
// straight from a register. Flush wins over push and pop.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int W = FETCH_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         pop_ok, push_ok;

  // Ignore a pop of an empty buffer and a push into a full one that is not popping
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  // Next occupancy and entry contents
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = push_data;
          else                 ent1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy register; only control state is reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // Entry storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign head  = ent0_q;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, a two-entry buffer
// toward decode, and redirect handling that discards an in-flight response.
// Optional macro IF_OPCODE_CHECK_EN enables the unsupported-opcode flag.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic            if_illegal
);

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   handshake;
  logic                   push, pop, flush;
  logic [1:0]             count;
  logic [FETCH_ENTRY_W-1:0] head;

  assign imem_req_valid = (state_q == REQ) && (count != 2'd2);
  assign handshake      = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;

  // Next state, next pc and buffer controls; redirect overrides everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (handshake) state_d = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      DROP: if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d  = redirect_pc;
      flush = 1'b1;
      push  = 1'b0;
      // A response arriving in the same cycle as the redirect is the stale one
      // and is discarded here, so there is nothing left to wait for.
      if ((state_q == REQ && handshake) ||
          ((state_q == WAIT || state_q == DROP) && !imem_rsp_valid))
        state_d = DROP;
      else
        state_d = REQ;
    end
  end

  // FSM state and fetch pc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pop = if_valid && if_ready;

  if_fifo #(.W(FETCH_ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pc_q, imem_rsp_data}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign if_valid  = (count != 2'd0);
  assign if_pc     = head[FETCH_ENTRY_W-1:ILEN];
  assign if_instr  = head[ILEN-1:0];
  assign if_opcode = if_instr[6:0];

`ifdef IF_OPCODE_CHECK_EN
  assign if_illegal = if_valid && !opcode_supported(if_opcode);
`else
  assign if_illegal = 1'b0;
`endif

endmodule
